// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux arbiter.
interface mux_rr_arbiter_if;
  localparam int unsigned N     = 4;
  localparam int unsigned SEL_W = 2;

  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;

  // Requester side: raises requests, observes grant and mux select.
  modport master (output req, input gnt, input sel, input busy);
  // Arbiter side: consumes requests, drives grant and mux select.
  modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 single-bit mux among four requesters.
// Registers a one-hot grant and the matching mux select code.
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN (forced rotation after HOLD_MAX cycles).
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int unsigned N      = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HCNT_W = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic [SEL_W:0]   pick_all;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [SEL_W:0]    pick_oth;
`endif

  // Reject an out-of-range hold limit at elaboration.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("mux_rr_arbiter: HOLD_MAX must be 1..255");
  end

  // Scan base+1, base+2, base+3, base; returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] r,
                                             input logic [SEL_W-1:0] base);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = base + SEL_W'(k);
      if (!res[SEL_W] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Candidate winners: full search, and search excluding the current owner.
  always_comb begin
    pick_all = rr_pick(bus.req, last_q);
`ifdef MUX_ARB_HOLD_LIMIT_EN
    pick_oth = rr_pick(bus.req & ~(N'(1) << last_q), last_q);
`endif
  end

  // State register plus registered grant, select, owner pointer and hold count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      last_q <= SEL_W'(N - 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hcnt_q <= '0;
`endif
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      last_q <= last_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hcnt_q <= hcnt_d;
`endif
    end
  end

  // Next state: leave IDLE on any request, return when the owner leaves with nobody waiting.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (|bus.req) state_d = GRANT;
      GRANT: if (!bus.req[last_q] && !pick_all[SEL_W]) state_d = IDLE;
    endcase
  end

  // Next grant/select/owner/hold values; the owner is always last_q while in GRANT.
  always_comb begin
    gnt_d  = gnt_q;
    sel_d  = sel_q;
    busy_d = busy_q;
    last_d = last_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hcnt_d = hcnt_q;
`endif
    unique case (state)
      IDLE: begin
        if (pick_all[SEL_W]) begin
          gnt_d  = N'(1) << pick_all[SEL_W-1:0];
          sel_d  = pick_all[SEL_W-1:0];
          busy_d = 1'b1;
          last_d = pick_all[SEL_W-1:0];
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hcnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[last_q]) begin
          if (pick_all[SEL_W]) begin
            gnt_d  = N'(1) << pick_all[SEL_W-1:0];
            sel_d  = pick_all[SEL_W-1:0];
            last_d = pick_all[SEL_W-1:0];
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hcnt_d = '0;
`endif
          end else begin
            gnt_d  = '0;
            busy_d = 1'b0;
          end
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        else if (hcnt_q == HCNT_W'(HOLD_MAX - 1) && pick_oth[SEL_W]) begin
          gnt_d  = N'(1) << pick_oth[SEL_W-1:0];
          sel_d  = pick_oth[SEL_W-1:0];
          last_d = pick_oth[SEL_W-1:0];
          hcnt_d = '0;
        end else if (hcnt_q != HCNT_W'(HOLD_MAX - 1)) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
`endif
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter, with a behavioural 4:1 mux on sel.
module tb_mux_rr_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] din;
  logic       y;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath mux: a=din[0], b=din[1], c=din[2], d=din[3].
  assign y = din[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] RR_REQ [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                        4'b1111, 4'b1011, 4'b1111, 4'b0111};
  localparam logic [3:0] RR_GNT [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                        4'b0100, 4'b1000, 4'b1000, 4'b0001};
  localparam logic [1:0] RR_SEL [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: gnt=%b sel=%b busy=%b, want 0000/00/0", i, bus.gnt, bus.sel, bus.busy);
      end
    end
    rst = 1'b0;
    bus.req = 4'b1010;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b sel=%b busy=%b, want 0010/01/1", bus.gnt, bus.sel, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.req = RR_REQ[i];
      tick();
      checks++;
      if (bus.gnt !== RR_GNT[i] || bus.sel !== RR_SEL[i] || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL round_robin cyc%0d: gnt=%b sel=%0d busy=%b, want %b/%0d/1", i, bus.gnt, bus.sel, bus.busy, RR_GNT[i], RR_SEL[i]);
      end
    end
  endtask

  // Continues from round-robin: owner 0 drops as requester 2 asks.
  task automatic test_release_idle();
    bus.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL release_hold cyc%0d: gnt=%b sel=%b busy=%b, want 0100/10/1", i, bus.gnt, bus.sel, bus.busy);
      end
    end
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.sel !== 2'b10 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL release_idle cyc%0d: gnt=%b sel=%b busy=%b, want 0000/10/0", i, bus.gnt, bus.sel, bus.busy);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp;
    do_reset();
    bus.req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef MUX_ARB_HOLD_LIMIT_EN
      exp = (((i / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp = 4'b0001;
`endif
      checks++;
      if (bus.gnt !== exp) begin
        errors++;
        $display("FAIL hold_limit cyc%0d: gnt=%b, want %b", i, bus.gnt, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11) begin
        errors++;
        $display("FAIL mid_hold cyc%0d: gnt=%b sel=%b, want 1000/11", i, bus.gnt, bus.sel);
      end
    end
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b sel=%b busy=%b, want 0000/00/0", bus.gnt, bus.sel, bus.busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'b00 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: gnt=%b sel=%b busy=%b, want 0001/00/1", bus.gnt, bus.sel, bus.busy);
    end
    // Owner 1 reset away: pointer must return to 3, so 1111 grants 0 rather than 2.
    do_reset();
    bus.req = 4'b0010;
    tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL last_ptr_reset: gnt=%b, want 0001", bus.gnt);
    end
  endtask

  task automatic test_mux_integration();
    logic [3:0] reqs [4];
    logic [1:0] sels [4];
    logic       ys   [4];
    reqs = '{4'b1000, 4'b0100, 4'b0001, 4'b0010};
    sels = '{2'd3, 2'd2, 2'd0, 2'd1};
    ys   = '{1'b0, 1'b1, 1'b1, 1'b0};
    din = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req = reqs[i];
      tick();
      checks++;
      if (bus.sel !== sels[i] || y !== ys[i]) begin
        errors++;
        $display("FAIL mux_y step%0d: sel=%0d y=%b, want sel=%0d y=%b", i, bus.sel, y, sels[i], ys[i]);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    din     = 4'b0000;
    test_reset();
    test_round_robin();
    test_release_idle();
    test_hold_limit();
    test_reset_mid();
    test_mux_integration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
